uart_rx_top: RTL and testbench
==============================

UART_RX_TOP -- requirements
Module: uart_rx_top

Interface
REQ-001 Parameter CLK_FREQ, default 100000000, system clock frequency in Hz.
REQ-002 Parameter BAUD, default 9600, serial bit rate in bit/s.
REQ-003 Port clk  input  1  system clock; all logic on the rising edge.
REQ-004 Port rst  input  1  reset; synchronous, active-high.
REQ-005 Port Rx  input  1  asynchronous serial line; idle high.
REQ-006 Port frame  output  9  received frame; [7:0] data byte (bit 0 first on the line), [8] received parity bit.
REQ-007 Port frame_valid  output  1  one-cycle pulse marking frame as newly valid.

Function
REQ-008 The block SHALL pass Rx through a 2-flop synchronizer; downstream logic SHALL use only the synchronized value.
REQ-009 The block SHALL treat a non-driven (X) or high synchronized Rx as idle.
REQ-010 Bit period SHALL be CLKS_PER_BIT = CLK_FREQ/BAUD (integer division; 10416 at the defaults).
REQ-011 The FSM SHALL have states IDLE, START, DATA, PARITY, STOP.
REQ-012 IDLE SHALL move to START on a synchronized falling edge of Rx.
REQ-013 START SHALL sample Rx at CLKS_PER_BIT/2: low moves to DATA, high (glitch) returns to IDLE.
REQ-014 DATA SHALL sample 8 bits, one CLKS_PER_BIT after the previous sample point, LSB first, then move to PARITY.
REQ-015 PARITY SHALL sample 1 bit one bit period later, then move to STOP.
REQ-016 STOP SHALL sample 1 bit one bit period later and then return to IDLE.
REQ-017 If the stop bit is high (and parity passes when checked), frame SHALL be loaded and frame_valid pulsed high for exactly 1 cycle, 1 cycle after the stop sample.
REQ-018 If the stop bit is low (framing error), the frame SHALL be discarded: no pulse, frame unchanged, FSM returns to IDLE and waits for Rx high before re-arming.
REQ-019 frame SHALL hold its last valid value until the next valid frame.
REQ-020 Back-to-back frames SHALL be accepted: a falling edge seen in IDLE immediately after STOP starts a new frame.

Reset
REQ-021 While rst=1 the block SHALL force: FSM to IDLE, counters to 0, synchronizer flops to 1, frame=9'h000, frame_valid=0.
REQ-022 rst asserted mid-frame SHALL abort the frame with no frame_valid pulse.
REQ-023 Reception SHALL start only on a falling edge seen after rst is released.

Configuration
REQ-024 Macro UART_PARITY_CHECK_EN, when defined, SHALL enable even-parity checking (data ones plus parity bit must be even); on a mismatch the frame is discarded like a framing error.
REQ-025 Without UART_PARITY_CHECK_EN, the parity bit SHALL be stored in frame[8] and not checked.

Structure
REQ-026 A shared package uart_pkg SHALL hold the FSM state typedef, the frame width constant (9), and the data width constant (8).
REQ-027 The baud/sample-point counter SHALL be a sub-module uart_baud_cnt, with a restart input and a sample-tick output.

Verification
REQ-028 Reset held 300 us, then 30 us idle, then line bits 0,1,0,1,0,0,1,1,1,1 (start, data LSB first, parity, stop) at 104.2 us per bit -> frame=9'h1E5, frame_valid one-cycle pulse about 0.5 bit after the stop bit begins.
REQ-029 Same frame with stop bit 0 -> no frame_valid; frame keeps its previous value.
REQ-030 UART_PARITY_CHECK_EN defined, data 0xE5 with parity 0 -> no pulse; same frame with parity 1 -> pulse, frame=9'h1E5.
REQ-031 2 us low glitch on idle Rx -> FSM returns to IDLE, no pulse.
REQ-032 rst asserted during data bit 4 -> no pulse, frame=9'h000; the next full frame 0x5A with parity 0 -> frame=9'h05A.
REQ-033 Two back-to-back frames 0x00 (parity 0) then 0xFF (parity 0) -> two pulses, frame=9'h000 then 9'h0FF.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART receiver types and constants: FSM states, frame/data widths,
// and the even-parity helper used when UART_PARITY_CHECK_EN is defined.
package uart_pkg;

    localparam int FRAME_W = 9;
    localparam int DATA_W  = 8;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } uart_state_e;

    // Even parity: data ones plus the parity bit must give an even count.
    function automatic logic even_parity_ok(input logic [DATA_W-1:0] data, input logic parity);
        return ~^{data, parity};
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Serial-in / frame-out bundle of the UART receiver; the line driver uses
// master, the receiver side uses slave.
interface uart_rx_if;
    import uart_pkg::*;

    logic               rx;
    logic [FRAME_W-1:0] frame;
    logic               frame_valid;

    modport master (output rx, input frame, input frame_valid);
    modport slave  (input rx, output frame, output frame_valid);

endinterface

// File: rtl/uart_baud_cnt.sv
// Bit-period counter: restart_i clears it, tick_o marks a sample point either
// half a bit (half_i=1) or a full bit after the previous restart/tick.
module uart_baud_cnt #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic clk,
    input  logic rst,
    input  logic restart_i,
    input  logic half_i,
    output logic tick_o
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    assign tick_o = (cnt_q == (half_i ? HALF_LAST : FULL_LAST));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (restart_i || tick_o) begin
            cnt_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_rx_top.sv
// 8-bit UART receiver with a received parity bit in frame[8].
// Define UART_PARITY_CHECK_EN to drop frames that fail even parity.
module uart_rx_top
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = 100000000,
    parameter int BAUD     = 9600
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               Rx,
    output logic [FRAME_W-1:0] frame,
    output logic               frame_valid
);

    localparam int CLKS_PER_BIT = CLK_FREQ / BAUD;

    logic [1:0]         sync_q;
    logic               rx_prev_q;
    logic               rx_s;
    logic               rx_fall;

    uart_state_e        state_q, state_d;
    logic [2:0]         bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]  data_q, data_d;
    logic               parity_q, parity_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic               valid_q, valid_d;

    logic               baud_restart;
    logic               baud_half;
    logic               baud_tick;
    logic               parity_ok;

    // An undriven (X) or high line both read as idle.
    assign rx_s    = (sync_q[1] === 1'b0) ? 1'b0 : 1'b1;
    assign rx_fall = rx_prev_q & ~rx_s;

`ifdef UART_PARITY_CHECK_EN
    assign parity_ok = even_parity_ok(data_q, parity_q);
`else
    assign parity_ok = 1'b1;
`endif

    uart_baud_cnt #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud_cnt (
        .clk       (clk),
        .rst       (rst),
        .restart_i (baud_restart),
        .half_i    (baud_half),
        .tick_o    (baud_tick)
    );

    // NOTE: every variable gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        bit_cnt_d    = bit_cnt_q;
        data_d       = data_q;
        parity_d     = parity_q;
        frame_d      = frame_q;
        valid_d      = 1'b0;
        baud_restart = 1'b0;
        baud_half    = 1'b0;

        unique case (state_q)
            IDLE: begin
                baud_restart = 1'b1;
                if (rx_fall) begin
                    state_d = START;
                end
            end
            START: begin
                baud_half = 1'b1;
                if (baud_tick) begin
                    bit_cnt_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (baud_tick) begin
                    data_d    = {rx_s, data_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = PARITY;
                    end
                end
            end
            PARITY: begin
                if (baud_tick) begin
                    parity_d = rx_s;
                    state_d  = STOP;
                end
            end
            STOP: begin
                if (baud_tick) begin
                    state_d = IDLE;
                    if (rx_s && parity_ok) begin
                        frame_d = {parity_q, data_q};
                        valid_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            data_q    <= '0;
            parity_q  <= 1'b0;
            frame_q   <= '0;
            valid_q   <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], Rx};
            rx_prev_q <= rx_s;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            data_q    <= data_d;
            parity_q  <= parity_d;
            frame_q   <= frame_d;
            valid_q   <= valid_d;
        end
    end

    assign frame       = frame_q;
    assign frame_valid = valid_q;

endmodule

// File: tb/tb_uart_rx_top.sv
// Self-checking bench for uart_rx_top: directed frames plus randomized traffic
// scored against a frame-level model (queue of expected frames).
`timescale 1ns/1ps
module tb_uart_rx_top;
    import uart_pkg::*;

    localparam int CLK_FREQ = 1_700_000;
    localparam int BAUD     = 100_000;
    localparam int CPB      = CLK_FREQ / BAUD;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    uart_rx_if u_if ();

    uart_rx_top #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .Rx          (u_if.rx),
        .frame       (u_if.frame),
        .frame_valid (u_if.frame_valid)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    logic [FRAME_W-1:0] exp_q[$];
    logic [FRAME_W-1:0] last_frame = '0;
    int                 stop_cyc   = 0;
    logic               prev_valid = 1'b0;

    // Monitor: every pulse must match the oldest expected frame, last one
    // cycle, and land inside the stop bit.
    always @(negedge clk) begin
        if (!rst) begin
            if (prev_valid) begin
                check("pulse_width", {31'd0, u_if.frame_valid}, 32'd0);
            end
            if (u_if.frame_valid) begin
                if (exp_q.size() == 0) begin
                    check("spurious_pulse", {31'd0, u_if.frame_valid}, 32'd0);
                end else begin
                    check("frame", {23'd0, u_if.frame}, {23'd0, exp_q.pop_front()});
                    check("latency", {31'd0, (cyc - stop_cyc >= CPB / 2) && (cyc - stop_cyc < CPB)}, 32'd1);
                end
            end
        end
        prev_valid = rst ? 1'b0 : u_if.frame_valid;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive_bit(input logic b);
        u_if.rx = b;
        wait_clks(CPB);
    endtask

    function automatic logic model_accepts(input logic [7:0] d, input logic p, input logic s);
`ifdef UART_PARITY_CHECK_EN
        return s && ((($countones(d) + int'(p)) % 2) == 0);
`else
        return s;
`endif
    endfunction

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int gap_bits);
        if (model_accepts(d, p, s)) begin
            exp_q.push_back({p, d});
            last_frame = {p, d};
        end
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
        drive_bit(p);
        stop_cyc = cyc;
        drive_bit(s);
        u_if.rx = 1'b1;
        wait_clks(gap_bits * CPB);
    endtask

    task automatic check_settled(input string tag);
        check({tag, "_pending"}, exp_q.size(), 32'd0);
        check({tag, "_hold"}, {23'd0, u_if.frame}, {23'd0, last_frame});
        exp_q.delete();
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        u_if.rx = 1'b1;
        rst     = 1'b1;
        wait_clks(20);
        check("reset_frame", {23'd0, u_if.frame}, 32'd0);
        check("reset_valid", {31'd0, u_if.frame_valid}, 32'd0);
        rst = 1'b0;
        wait_clks(3 * CPB);

        // Reference frame 0xE5 with parity 1 and 0.
        send_frame(8'hE5, 1'b1, 1'b1, 2);
        check_settled("e5_p1");
        send_frame(8'hE5, 1'b0, 1'b1, 2);
        check_settled("e5_p0");

        // Framing error: frame dropped, previous value held.
        send_frame(8'h3C, 1'b0, 1'b0, 3);
        check_settled("framing_err");

        // Short low glitch on an idle line.
        u_if.rx = 1'b0;
        wait_clks(2);
        u_if.rx = 1'b1;
        wait_clks(2 * CPB);
        check_settled("glitch");

        // Reset during data bit 4 aborts the frame and clears frame.
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        u_if.rx = 1'b0;
        wait_clks(CPB / 2);
        rst = 1'b1;
        wait_clks(5);
        u_if.rx = 1'b1;
        rst = 1'b0;
        last_frame = '0;
        wait_clks(2 * CPB);
        check_settled("mid_reset");
        send_frame(8'h5A, 1'b0, 1'b1, 2);
        check_settled("after_reset");

        // Back-to-back frames with no idle gap between them.
        send_frame(8'h00, 1'b0, 1'b1, 0);
        send_frame(8'hFF, 1'b0, 1'b1, 2);
        check_settled("back_to_back");

        // Randomized traffic.
        for (int n = 0; n < 30; n++) begin
            logic [7:0] d;
            logic       p;
            logic       s;
            d = 8'($urandom_range(0, 255));
            p = 1'($urandom_range(0, 1));
            s = ($urandom_range(0, 4) != 0);
            send_frame(d, p, s, $urandom_range(1, 3));
            check_settled("random");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
